// File: rtl/request_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : request_issue_stage
// Purpose  : Two-entry issue buffer driving the request/valid/ack handshake,
//            with a sticky stall watchdog and a wrapping issue counter.
// Revision : 1.0 - initial release
// ============================================================================
module request_issue_stage #(
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32,
   parameter int TIMEOUT_CYCLES             = 64,
   parameter int COUNTER_WIDTH_IN_BITS      = 32
) (
   input  logic                                  clk_in,
   input  logic                                  reset_in,
   input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
   input  logic                                  request_valid_in,
   output logic                                  issue_ack_out,
   output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
   output logic                                  request_valid_out,
   input  logic                                  issue_ack_in,
   output logic                                  is_empty_out,
   output logic                                  is_full_out,
   output logic                                  timeout_out,
   output logic [COUNTER_WIDTH_IN_BITS-1:0]      issued_count_out
);

   localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                                r_state;
   state_t                                w_state_next;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] r_head;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] r_tail;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] w_head_next;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] w_tail_next;
   logic [15:0]                           r_stall_count;
   logic                                  r_timeout;
   logic [COUNTER_WIDTH_IN_BITS-1:0]      r_issued_count;
   logic                                  w_push;
   logic                                  w_pop;
   logic                                  w_stalled;

   // Handshake outputs decode registered state only; no path from request_valid_in.
   assign issue_ack_out     = (r_state != ST_TWO);
   assign request_valid_out = (r_state != ST_EMPTY);
   assign is_empty_out      = (r_state == ST_EMPTY);
   assign is_full_out       = (r_state == ST_TWO);
   assign request_out       = r_head;
   assign timeout_out       = r_timeout;
   assign issued_count_out  = r_issued_count;

   assign w_push    = request_valid_in && issue_ack_out;
   assign w_pop     = request_valid_out && issue_ack_in;
   assign w_stalled = request_valid_out && !issue_ack_in;

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_state <= ST_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_state_next;
         r_head  <= w_head_next;
         r_tail  <= w_tail_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_head_next  = r_head;
      w_tail_next  = r_tail;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_state_next = ST_ONE;
               w_head_next  = request_in;
            end
         end
         ST_ONE: begin
            if (w_push && w_pop) begin
               w_head_next = request_in;
            end else if (w_push) begin
               w_state_next = ST_TWO;
               w_tail_next  = request_in;
            end else if (w_pop) begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_pop) begin
               w_state_next = ST_ONE;
               w_head_next  = r_tail;
            end
         end
         default: begin
            w_state_next = ST_EMPTY;
         end
      endcase
   end

   // Stall counter saturates at the threshold; the flag stays set until reset.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_stall_count <= '0;
         r_timeout     <= 1'b0;
      end else begin
         if (w_pop || (r_state == ST_EMPTY)) begin
            r_stall_count <= '0;
         end else if (w_stalled && (r_stall_count != c_timeout)) begin
            r_stall_count <= r_stall_count + 16'd1;
         end
         if (w_stalled && (r_stall_count == (c_timeout - 16'd1))) begin
            r_timeout <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_issued_count <= '0;
      end else if (w_pop) begin
         r_issued_count <= r_issued_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_request_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_request_issue_stage
// Purpose  : Directed self-checking bench for request_issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_request_issue_stage;

   logic        clk_in = 1'b0;
   logic        reset_in = 1'b0;
   logic [31:0] request_in = '0;
   logic        request_valid_in = 1'b0;
   logic        issue_ack_out;
   logic [31:0] request_out;
   logic        request_valid_out;
   logic        issue_ack_in = 1'b0;
   logic        is_empty_out;
   logic        is_full_out;
   logic        timeout_out;
   logic [31:0] issued_count_out;

   int n_checks = 0;
   int n_errors = 0;

   request_issue_stage #(
      .SINGLE_ENTRY_WIDTH_IN_BITS(32),
      .TIMEOUT_CYCLES            (4),
      .COUNTER_WIDTH_IN_BITS     (32)
   ) dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .request_in       (request_in),
      .request_valid_in (request_valid_in),
      .issue_ack_out    (issue_ack_out),
      .request_out      (request_out),
      .request_valid_out(request_valid_out),
      .issue_ack_in     (issue_ack_in),
      .is_empty_out     (is_empty_out),
      .is_full_out      (is_full_out),
      .timeout_out      (timeout_out),
      .issued_count_out (issued_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      request_valid_in = 1'b0;
      issue_ack_in     = 1'b0;
      request_in       = '0;
      reset_in         = 1'b0;
      step();
      step();
      reset_in = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 1, 0);
      $fatal(1, "bench did not terminate");
   end

   initial begin
      // Reset state
      do_reset();
      check_value("rst_ack_out",   {31'd0, issue_ack_out},     32'd1);
      check_value("rst_valid_out", {31'd0, request_valid_out}, 32'd0);
      check_value("rst_empty",     {31'd0, is_empty_out},      32'd1);
      check_value("rst_full",      {31'd0, is_full_out},       32'd0);
      check_value("rst_count",     issued_count_out,           32'd0);
      check_value("rst_timeout",   {31'd0, timeout_out},       32'd0);
      check_value("rst_req_out",   request_out,                32'd0);

      // Streaming: FFFFFFFE down to FFFFFFF7 with ack held high
      issue_ack_in     = 1'b1;
      request_valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         request_in = 32'hFFFF_FFFE - 32'(i);
         step();
         check_value("stream_valid", {31'd0, request_valid_out}, 32'd1);
         check_value("stream_data",  request_out, 32'hFFFF_FFFE - 32'(i));
         check_value("stream_full",  {31'd0, is_full_out}, 32'd0);
      end
      request_valid_in = 1'b0;
      step();
      check_value("stream_count", issued_count_out, 32'd8);
      check_value("stream_empty", {31'd0, is_empty_out}, 32'd1);

      // Fill and back-pressure
      do_reset();
      request_valid_in = 1'b1;
      request_in       = 32'hA;
      step();
      request_in = 32'hB;
      step();
      check_value("fill_full",    {31'd0, is_full_out},   32'd1);
      check_value("fill_ack_out", {31'd0, issue_ack_out}, 32'd0);
      check_value("fill_head_a",  request_out,            32'hA);
      request_in = 32'hC;
      step();
      check_value("fill_c_reject_full", {31'd0, is_full_out}, 32'd1);
      check_value("fill_c_reject_head", request_out,          32'hA);
      issue_ack_in = 1'b1;
      step();
      check_value("fill_head_b",   request_out,            32'hB);
      check_value("fill_reopen",   {31'd0, issue_ack_out}, 32'd1);
      check_value("fill_count1",   issued_count_out,       32'd1);
      step();
      check_value("fill_head_c",   request_out,            32'hC);
      check_value("fill_count2",   issued_count_out,       32'd2);
      request_valid_in = 1'b0;
      step();
      check_value("fill_count3",   issued_count_out,       32'd3);
      check_value("fill_empty",    {31'd0, is_empty_out},  32'd1);

      // Simultaneous push and pop while holding one entry
      do_reset();
      request_valid_in = 1'b1;
      request_in       = 32'h11;
      step();
      check_value("pp_head_11", request_out, 32'h11);
      request_in   = 32'h22;
      issue_ack_in = 1'b1;
      step();
      check_value("pp_head_22", request_out,                32'h22);
      check_value("pp_one_full", {31'd0, is_full_out},      32'd0);
      check_value("pp_one_empty", {31'd0, is_empty_out},    32'd0);
      check_value("pp_count",    issued_count_out,          32'd1);

      // Watchdog with threshold 4
      do_reset();
      request_valid_in = 1'b1;
      request_in       = 32'h5;
      step();
      request_valid_in = 1'b0;
      check_value("wd_pre", {31'd0, timeout_out}, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         step();
         check_value("wd_stall_edge", {31'd0, timeout_out}, (k == 4) ? 32'd1 : 32'd0);
      end
      step();
      step();
      check_value("wd_saturated", {31'd0, timeout_out}, 32'd1);
      check_value("wd_head_held", request_out, 32'h5);
      issue_ack_in = 1'b1;
      step();
      check_value("wd_sticky_pop",  {31'd0, timeout_out}, 32'd1);
      check_value("wd_pop_count",   issued_count_out,     32'd1);
      step();
      check_value("wd_sticky_idle", {31'd0, timeout_out}, 32'd1);
      do_reset();
      check_value("wd_cleared", {31'd0, timeout_out}, 32'd0);

      // Ack while empty is ignored
      issue_ack_in = 1'b1;
      step();
      step();
      check_value("eack_count", issued_count_out, 32'd0);
      check_value("eack_empty", {31'd0, is_empty_out}, 32'd1);
      check_value("eack_valid", {31'd0, request_valid_out}, 32'd0);

      // Reset mid-flight with the buffer full
      issue_ack_in     = 1'b0;
      request_valid_in = 1'b1;
      request_in       = 32'h77;
      step();
      request_in = 32'h88;
      step();
      request_valid_in = 1'b0;
      check_value("mf_full", {31'd0, is_full_out}, 32'd1);
      #3;
      reset_in = 1'b0;
      #1;
      check_value("mf_async_valid", {31'd0, request_valid_out}, 32'd0);
      check_value("mf_async_empty", {31'd0, is_empty_out},      32'd1);
      check_value("mf_async_data",  request_out,                32'd0);
      step();
      reset_in     = 1'b1;
      issue_ack_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_value("mf_no_stale", {31'd0, request_valid_out}, 32'd0);
      end
      check_value("mf_count", issued_count_out, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/request_issue_stage.md
# request_issue_stage

Two-entry issue buffer that acts as the initiator on the request/valid/ack handshake used by `fifo_queue`. It accepts requests from an upstream producer and drives them into a downstream consumer, normally the input port of a `fifo_queue`. Each request is held stable until that consumer acknowledges it. A stall watchdog and an issue counter give the sim benches and performance logic visibility into back-pressure.

## Interface
- `SINGLE_ENTRY_WIDTH_IN_BITS`, 32: request payload width.
- `TIMEOUT_CYCLES`, 64: consecutive unacknowledged cycles before the watchdog fires. Legal range 1..65535.
- `COUNTER_WIDTH_IN_BITS`, 32: width of `issued_count_out`.
- `clk_in`, in, 1: single clock; all state updates on rising edge.
- `reset_in`, in, 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately; deassertion is synchronous to `clk_in`.
- `request_in`, in, `SINGLE_ENTRY_WIDTH_IN_BITS`: upstream payload.
- `request_valid_in`, in, 1: upstream payload valid.
- `issue_ack_out`, out, 1: buffer can accept this cycle. A transfer happens when `request_valid_in && issue_ack_out` at the edge.
- `request_out`, out, `SINGLE_ENTRY_WIDTH_IN_BITS`: payload of the head entry.
- `request_valid_out`, out, 1: head entry valid.
- `issue_ack_in`, in, 1: downstream accepted the head. A transfer happens when `request_valid_out && issue_ack_in` at the edge.
- `is_empty_out`, out, 1: zero entries held.
- `is_full_out`, out, 1: two entries held.
- `timeout_out`, out, 1: sticky watchdog flag.
- `issued_count_out`, out, `COUNTER_WIDTH_IN_BITS`: number of completed downstream transfers, wrapping.

## Operation
- Storage is a head register and a tail register. Occupancy state is one of EMPTY, ONE, TWO.
- `issue_ack_out` = (state != TWO). It is a function of registered state only, with no combinational path from `request_valid_in`.
- `request_valid_out` = (state != EMPTY).
- `request_out` = head register. It must not change while `request_valid_out` is high and no downstream transfer has occurred.
- State transitions per edge, where push = upstream transfer and pop = downstream transfer:
  - EMPTY: push → ONE, and head ← `request_in`. Otherwise stay in EMPTY.
  - ONE, push only → TWO, and tail ← `request_in`.
  - ONE, pop only → EMPTY.
  - ONE, push and pop → stay in ONE, and head ← `request_in`.
  - ONE, neither → stay in ONE.
  - TWO, pop → ONE, and head ← tail. Push is impossible in TWO because `issue_ack_out` is low.
- Requests leave in strict arrival order; none are dropped or duplicated.
- Downstream `issue_ack_in` while `request_valid_out` is low is ignored: no state change and no count.
- Upstream `request_in` while `request_valid_in` is low is ignored.
- Stall counter, 16-bit:
  - Increments on each edge where `request_valid_out && !issue_ack_in`.
  - Clears on any pop and while EMPTY.
  - Saturates at `TIMEOUT_CYCLES`.
  - When it reaches `TIMEOUT_CYCLES`, `timeout_out` is set. It stays set until reset, even if the stall later clears.
- `issued_count_out` increments by 1 on every pop and wraps from all-ones to 0.
- `is_empty_out` = (state == EMPTY); `is_full_out` = (state == TWO).

## Timing
- Reset values:
  - State = EMPTY, so `request_valid_out` = 0, `issue_ack_out` = 1, `is_empty_out` = 1, `is_full_out` = 0.
  - `request_out` = 0, `timeout_out` = 0, `issued_count_out` = 0, stall counter = 0.
- Reset mid-operation: entries held in the buffer are discarded without being issued, and the counters clear. Outputs take their reset values asynchronously when `reset_in` falls.
- Latency: a request accepted at edge N appears on `request_out` with `request_valid_out` high from edge N up to edge N+1, with no bubble. Cut-through from input to output in the same cycle is not allowed.
- Throughput:
  - One request per cycle in ONE with `issue_ack_in` held high.
  - In TWO, the cycle after a pop re-opens `issue_ack_out`.
- Watchdog: with the head valid and `issue_ack_in` low from edge M onward, `timeout_out` rises at edge M + `TIMEOUT_CYCLES` − 1.
- All outputs are registered or decoded from registered state only, so they are glitch-free relative to the inputs.

## Test plan
- Reset state: hold `reset_in` low, then release. Expect `issue_ack_out`=1, `request_valid_out`=0, `is_empty_out`=1, `issued_count_out`=0, `timeout_out`=0.
- Streaming: push 0xFFFFFFFE down to 0xFFFFFFF7 (8 values) back-to-back with `issue_ack_in`=1. Expect the same 8 values, in order, on consecutive cycles, one cycle after each push, state never TWO, and `issued_count_out`=8.
- Fill and back-pressure:
  - With `issue_ack_in`=0, push 0xA and 0xB; expect `is_full_out`=1 and `issue_ack_out`=0.
  - A third push of 0xC is not accepted.
  - Raise `issue_ack_in`: outputs are 0xA then 0xB; 0xC is accepted after the first pop; final output order is A, B, C.
- Simultaneous push/pop in ONE: hold head 0x11, then push 0x22 in the same cycle as an ack. Expect state ONE, `request_out`=0x22, count +1.
- Watchdog: with `TIMEOUT_CYCLES`=4, push 0x5 and hold `issue_ack_in`=0. Expect `timeout_out` to rise on the 4th stalled edge. After acking, `timeout_out` stays 1 until reset.
- Empty ack and reset mid-flight:
  - Pulse `issue_ack_in` while EMPTY: no change, count stays 0.
  - Fill to TWO, then pull `reset_in` low mid-cycle: `request_valid_out` drops immediately, and no stale entry is issued after release.
